// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the Wishbone command dispatcher.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [31:0] STATUS_IDX  = 32'h0000_0010;
    localparam logic [31:0] RESULT_IDX  = 32'h0000_0011;
    // Word index that the slave stage presents for opcode-config writes.
    localparam logic [31:0] OPCODE_ADDR = 32'h3FFF_FFFF;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_TIMEOUT = 3;

    function automatic logic [31:0] status_word(input logic busy, input logic done,
                                                input logic err, input logic tmo);
        logic [31:0] w;
        w               = '0;
        w[STAT_BUSY]    = busy;
        w[STAT_DONE]    = done;
        w[STAT_ERR]     = err;
        w[STAT_TIMEOUT] = tmo;
        return w;
    endfunction

endpackage

// File: rtl/wb_cmd_dispatch.sv
// Operand bank plus single-outstanding command launcher toward the compute core,
// with response timeout and combinational register readback.
//
//   state    | meaning
//   ---------+-----------------------------------------------------
//   ST_IDLE  | no command in flight; opcode/operand writes accepted
//   ST_ISSUE | cmd_valid held until the core asserts cmd_ready
//   ST_WAIT  | waiting for rsp_valid, timer counting toward abort
module wb_cmd_dispatch
    import wb_cmd_pkg::*;
#(
    parameter int NUM_OPERANDS = 4,
    parameter int OPCODE_W     = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      config_en,
    input  logic                      wb_write_req,
    input  logic                      wb_read_req,
    input  logic [31:0]               wishbone_addr,
    input  logic [31:0]               wishbone_data,
    output logic [31:0]               wishbone_output,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [OPCODE_W-1:0]       cmd_opcode,
    output logic [32*NUM_OPERANDS-1:0] cmd_operands,
    input  logic                      rsp_valid,
    input  logic [31:0]               rsp_data,
    output logic                      done_irq
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                wr_pend, op_pend;
    logic [OPCODE_W-1:0] opcode_q;
    logic [31:0]         operand_q [NUM_OPERANDS];
    logic [31:0]         result_q;
    logic                done_q, err_q, tmo_q;

    logic                busy;
    logic                opnd_hit;
    logic                rsp_take;
    logic                tmo_hit;
    logic                busy_wr_err;
    logic                rd_clr;

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        opnd_hit = 1'b0;
        for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (wishbone_addr == 32'(i)) opnd_hit = 1'b1;
        end
    end

    // A busy write is an error whether it targets the opcode or an operand.
    assign busy_wr_err = busy & (op_pend | (wr_pend & opnd_hit));
    assign rd_clr      = wb_read_req & (wishbone_addr == STATUS_IDX);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_pend <= 1'b0;
            op_pend <= 1'b0;
        end else begin
            wr_pend <= wb_write_req;
            op_pend <= config_en & wb_write_req;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rsp_take = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_pend) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    rsp_take = 1'b1;
                    state_d  = ST_IDLE;
                end else if (timer_q == TMAX) begin
                    tmo_hit = 1'b1;
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            opcode_q <= '0;
            result_q <= '0;
            for (int i = 0; i < NUM_OPERANDS; i++) operand_q[i] <= '0;
        end else begin
            if (!busy && op_pend) opcode_q <= wishbone_data[OPCODE_W-1:0];
            if (rsp_take) result_q <= rsp_data;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (!busy && wr_pend && !op_pend && (wishbone_addr == 32'(i)))
                    operand_q[i] <= wishbone_data;
            end
        end
    end

    // Set events beat a same-edge read-to-clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            if (rsp_take)                  done_q <= 1'b1;
            else if (rd_clr)               done_q <= 1'b0;
            if (tmo_hit || busy_wr_err)    err_q  <= 1'b1;
            else if (rd_clr)               err_q  <= 1'b0;
            if (tmo_hit)                   tmo_q  <= 1'b1;
            else if (rd_clr)               tmo_q  <= 1'b0;
        end
    end

    always_comb begin
        wishbone_output = '0;
        if (wishbone_addr == STATUS_IDX) begin
            wishbone_output = status_word(busy, done_q, err_q, tmo_q);
        end else if (wishbone_addr == RESULT_IDX) begin
            wishbone_output = result_q;
        end else begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (wishbone_addr == 32'(i)) wishbone_output = operand_q[i];
            end
        end
    end

    always_comb begin
        cmd_operands = '0;
        for (int i = 0; i < NUM_OPERANDS; i++) cmd_operands[32*i +: 32] = operand_q[i];
    end

    assign cmd_valid  = (state_q == ST_ISSUE);
    assign cmd_opcode = opcode_q;
    assign done_irq   = done_q;

endmodule

// File: doc/wb_cmd_dispatch.md
# wb_cmd_dispatch

Command dispatcher directly downstream of the Wishbone slave control stage. It consumes that stage's decoded write/read strobes, word address, write data and opcode-config strobe. It holds an operand register bank and launches one opcode at a time to the compute core over a valid/ready handshake. It waits for the core's response with a timeout, and serves operand, status and result readback through `wishbone_output`.

## Interface
- `NUM_OPERANDS`, 4: number of 32-bit operand registers, word indices 0..NUM_OPERANDS-1.
- `OPCODE_W`, 8: opcode width, taken from `wishbone_data[OPCODE_W-1:0]`.
- `TIMEOUT`, 1024: maximum cycles in WAIT before abort; must be ≥2.
- `wb_clk_i` input 1: the single clock.
- `wb_rst_n_i` input 1: reset, asynchronous and active-low.
- `config_en` input 1: opcode-address request strobe, combinational, valid in the request cycle.
- `wb_write_req` input 1: write strobe, one cycle.
- `wb_read_req` input 1: read strobe, one cycle.
- `wishbone_addr` input 32: word index.
- `wishbone_data` input 32: write data, valid the cycle after `wb_write_req`.
- `wishbone_output` output 32: read data, combinational on `wishbone_addr`.
- `cmd_valid` output 1: command offered to the core.
- `cmd_ready` input 1: core accepts the command.
- `cmd_opcode` output OPCODE_W: opcode of the current command.
- `cmd_operands` output 32*NUM_OPERANDS: operand bank, flat, operand 0 in the LSBs.
- `rsp_valid` input 1: core result strobe, one cycle.
- `rsp_data` input 32: core result.
- `done_irq` output 1: equals the status `done` bit.

## Operation
- Write capture:
  - Register `wb_write_req` to get `wr_pend`, and `config_en & wb_write_req` to get `op_pend`.
  - On a `wr_pend` cycle, the address and data are valid; commit the write that cycle.
  - `op_pend` takes priority over the address decode, since the opcode address decodes to 0x3FFFFFFF.
- Address map:
  - Operands at 0..NUM_OPERANDS-1, read/write.
  - STATUS at 0x10, read-only: bit0 busy, bit1 done, bit2 err, bit3 timeout, rest 0.
  - RESULT at 0x11, read-only.
  - Any other index reads 0; writes to it are ignored.
- FSM states:
  - IDLE: on `op_pend`, latch the opcode and go to ISSUE.
  - ISSUE: `cmd_valid`=1; on `cmd_ready`, go to WAIT and clear the timer.
  - WAIT: on `rsp_valid`, latch RESULT, set done, go to IDLE. If the timer reaches TIMEOUT-1 with no response, set err and timeout and go to IDLE.
- busy = (state != IDLE).
- Writes while busy:
  - An opcode write in ISSUE or WAIT is dropped and sets err.
  - An operand write in ISSUE or WAIT is dropped and sets err. Operands stay stable for the whole command.
- Read-to-clear:
  - A `wb_read_req` at STATUS clears done, err and timeout on the next edge.
  - The value returned on that cycle is the pre-clear value.
  - If a set event happens on the same edge, the set wins.
- `rsp_valid` outside WAIT is ignored and RESULT is not updated.
- `cmd_opcode` and `cmd_operands` hold their last values in IDLE.
- Reset, at any state: state IDLE; operands, opcode, RESULT and status 0; timer 0; `cmd_valid` 0. An in-flight command is abandoned.

## Timing
- Reset values: `cmd_valid`=0, `cmd_opcode`=0, `cmd_operands`=0, `done_irq`=0. `wishbone_output` = decode of the registers, all 0.
- Operand write: visible on `cmd_operands` and on readback 2 edges after the `wb_write_req` cycle.
- Opcode write: `cmd_valid` rises 2 edges after the `wb_write_req` cycle.
- `cmd_valid` and `cmd_opcode` are held stable until the edge at which `cmd_ready`=1.
- A `rsp_valid` in WAIT sets `done_irq` on the following edge.
- Timeout: err and timeout assert exactly TIMEOUT cycles after the handshake edge.
- Back-to-back: a new opcode write is accepted in the cycle after returning to IDLE.
- Read path: zero latency; `wishbone_output` is combinational from `wishbone_addr` and the registers.

## Structure
- Shared package `wb_cmd_pkg`:
  - state enum (IDLE, ISSUE, WAIT);
  - STATUS_IDX = 0x10 and RESULT_IDX = 0x11;
  - status bit positions;
  - the opcode address sentinel 0x3FFFFFFF.
- No sub-module is required. The timeout counter stays inline, with width $clog2(TIMEOUT).

## Test plan
- Write 0xDEADBEEF to operand 2, then read operand 2 → `wishbone_output`=0xDEADBEEF. `cmd_operands[95:64]`=0xDEADBEEF.
- Opcode write 0x05 with `cmd_ready` held 0 for 3 cycles → `cmd_valid` high 4 cycles with `cmd_opcode`=0x05. A `rsp_valid` with `rsp_data`=0x12345678 → RESULT reads 0x12345678, STATUS reads 0x2, `done_irq`=1.
- STATUS read after done → returns 0x2, then 0x0 on the next read; `done_irq` drops.
- In WAIT, write 0xFFFFFFFF to operand 0 → operand 0 unchanged; STATUS=0x5 (busy, err).
- TIMEOUT=16 with no `rsp_valid` → exactly 16 cycles after the handshake, STATUS=0xC and state IDLE.
- Assert `wb_rst_n_i` low asynchronously mid-WAIT → `cmd_valid`=0 and all registers 0 immediately. After release, a new opcode issues normally.
